amp_spi_ctrl: RTL and testbench

Parametrised SPI controller for the programmable preamplifier ahead of the ADC, successor to the fixed 2-channel 8-bit gain loader. One full-duplex shifter with a built-in SCK divider replaces the separate divider/MOSI/MISO chains. Each transfer loads CHANNELS gain codes and captures the word the amplifier shifts back, which is checked against the previously written word. Sits between the sampling control FSM and the shared SPI bus pins.

---
 rtl/amp_spi_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_amp_spi_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_spi_ctrl.sv
// SPI controller for the programmable ADC preamplifier: loads CHANNELS gain codes per frame
// through one full-duplex shifter and checks the shifted-back word against the previous write.
module amp_spi_ctrl #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_BITS  = 4,
    parameter int unsigned DIV      = 5
) (
    input  logic                         CLK50MHZ,
    input  logic                         RST,
    input  logic                         trig,
    input  logic [CHANNELS*CH_BITS-1:0]  data_in,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS*CH_BITS-1:0]  data_out,
    output logic                         readback_err,
    input  logic                         err_clr,
    input  logic                         shdn_req,
    output logic                         spi_sck,
    output logic                         spi_mosi,
    input  logic                         amp_dout,
    output logic                         amp_cs,
    output logic                         amp_shdn
);

    localparam int unsigned WIDTH = CHANNELS * CH_BITS;
    localparam int unsigned DivW  = $clog2(DIV + 1);
    localparam int unsigned BitW  = $clog2(WIDTH + 1);

    localparam logic [DivW-1:0] DivLoad = DivW'(DIV - 1);
    localparam logic [BitW-1:0] BitLoad = BitW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]  tx_q, tx_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [WIDTH-1:0]  rx_q, rx_d;
    logic [WIDTH-1:0]  last_tx_q, last_tx_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              first_done_q, first_done_d;
    logic              err_q, err_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              shdn_q, shdn_d;

    logic              div_zero;
    logic              err_set;
    logic [WIDTH:0]    rx_ext;
    logic [WIDTH-1:0]  tx_shift;

    assign div_zero = (div_q == '0);
    assign rx_ext   = {rx_q, amp_dout};
    assign tx_shift = tx_q << 1;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        tx_d         = tx_q;
        word_d       = word_q;
        rx_d         = rx_q;
        last_tx_d    = last_tx_q;
        data_out_d   = data_out_q;
        first_done_d = first_done_q;
        sck_d        = sck_q;
        mosi_d       = mosi_q;
        cs_d         = cs_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        shdn_d       = shdn_req;
        err_set      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d = StSetup;
                    tx_d    = data_in;
                    word_d  = data_in;
                    rx_d    = '0;
                    mosi_d  = data_in[WIDTH-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = DivLoad;
                    bit_d   = BitLoad;
                end
            end
            StSetup: begin
                if (div_zero) begin
                    state_d = StShift;
                    sck_d   = 1'b1;
                    rx_d    = rx_ext[WIDTH-1:0];
                    div_d   = DivLoad;
                end else begin
                    div_d = div_q - DivW'(1);
                end
            end
            StShift: begin
                if (div_zero) begin
                    div_d = DivLoad;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = rx_ext[WIDTH-1:0];
                    end else begin
                        sck_d = 1'b0;
                        bit_d = bit_q - BitW'(1);
                        // On the final fall MOSI keeps the last bit through HOLD.
                        if (bit_q == BitW'(1)) begin
                            state_d = StHold;
                        end else begin
                            tx_d   = tx_shift;
                            mosi_d = tx_shift[WIDTH-1];
                        end
                    end
                end else begin
                    div_d = div_q - DivW'(1);
                end
            end
            StHold: begin
                if (div_zero) begin
                    state_d      = StIdle;
                    cs_d         = 1'b1;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    data_out_d   = rx_q;
                    last_tx_d    = word_q;
                    first_done_d = 1'b1;
                    err_set      = first_done_q && (rx_q != last_tx_q);
                end else begin
                    div_d = div_q - DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A mismatch detected on the same edge as err_clr must stay visible.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            div_q        <= '0;
            bit_q        <= '0;
            tx_q         <= '0;
            word_q       <= '0;
            rx_q         <= '0;
            last_tx_q    <= '0;
            data_out_q   <= '0;
            first_done_q <= 1'b0;
            err_q        <= 1'b0;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
            cs_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            shdn_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            tx_q         <= tx_d;
            word_q       <= word_d;
            rx_q         <= rx_d;
            last_tx_q    <= last_tx_d;
            data_out_q   <= data_out_d;
            first_done_q <= first_done_d;
            err_q        <= err_d;
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
            cs_q         <= cs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            shdn_q       <= shdn_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign data_out     = data_out_q;
    assign readback_err = err_q;
    assign spi_sck      = sck_q;
    assign spi_mosi     = mosi_q;
    assign amp_cs       = cs_q;
    assign amp_shdn     = shdn_q;

endmodule

// File: tb/tb_amp_spi_ctrl.sv
// Bench for amp_spi_ctrl: default build (8-bit word, DIV=5) and a 12-bit DIV=1 build side by side,
// each checked every cycle against a frame-timing model plus directed literal expectations.
module tb_amp_spi_ctrl;

    logic        clk;
    logic        RST;
    logic [1:0]  trig, err_clr, shdn_req, amp_dout;
    logic [31:0] data_in [2];
    logic [1:0]  busy, done, rb_err, sck, mosi, cs, shdn;
    logic [7:0]  dout_a;
    logic [11:0] dout_b;

    int          checks = 0;
    int          errors = 0;
    int          n = 0;

    // Model state, one slot per DUT.
    bit          active [2];
    int          k [2];
    logic [31:0] word [2], echo_cur [2], echo_next [2], last_tx [2], exp_dout [2];
    bit          first [2], err [2];
    logic [31:0] cap [2];
    int          rises [2];
    logic [1:0]  sck_prev;

    amp_spi_ctrl u_dut_a (
        .CLK50MHZ(clk), .RST(RST), .trig(trig[0]), .data_in(data_in[0][7:0]),
        .busy(busy[0]), .done(done[0]), .data_out(dout_a), .readback_err(rb_err[0]),
        .err_clr(err_clr[0]), .shdn_req(shdn_req[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
        .amp_dout(amp_dout[0]), .amp_cs(cs[0]), .amp_shdn(shdn[0])
    );

    amp_spi_ctrl #(.CHANNELS(3), .CH_BITS(4), .DIV(1)) u_dut_b (
        .CLK50MHZ(clk), .RST(RST), .trig(trig[1]), .data_in(data_in[1][11:0]),
        .busy(busy[1]), .done(done[1]), .data_out(dout_b), .readback_err(rb_err[1]),
        .err_clr(err_clr[1]), .shdn_req(shdn_req[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
        .amp_dout(amp_dout[1]), .amp_cs(cs[1]), .amp_shdn(shdn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int divof(input int d);
        return (d == 0) ? 5 : 1;
    endfunction

    function automatic int wof(input int d);
        return (d == 0) ? 8 : 12;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, n, act, exp);
        end
    endtask

    // Frame model: outputs follow directly from the cycle offset m since the accepting edge.
    always @(posedge clk) begin : model
        logic [1:0]  trig_s, clr_s, shdn_s;
        logic        rst_s;
        logic [31:0] din_s [2];
        trig_s = trig;
        clr_s  = err_clr;
        shdn_s = shdn_req;
        rst_s  = RST;
        din_s  = data_in;
        #1;
        n++;
        for (int d = 0; d < 2; d++) begin : per_dut
            int          dv, w, tt, m, j, q;
            logic [31:0] mask, act_dout;
            logic        set_e, e_cs, e_sck, e_busy, e_done, e_mosi, e_shdn;
            dv    = divof(d);
            w     = wof(d);
            tt    = dv * (2 * w + 1);
            mask  = (32'd1 << w) - 32'd1;
            set_e = 1'b0;
            if (!rst_s) begin
                active[d]   = 1'b0;
                first[d]    = 1'b0;
                last_tx[d]  = '0;
                err[d]      = 1'b0;
                exp_dout[d] = '0;
            end else begin
                if (active[d] && (n - k[d] == tt)) begin
                    exp_dout[d] = echo_cur[d];
                    set_e       = first[d] && (echo_cur[d] != last_tx[d]);
                    last_tx[d]  = word[d];
                    first[d]    = 1'b1;
                end
                if (set_e) err[d] = 1'b1;
                else if (clr_s[d]) err[d] = 1'b0;
                if (trig_s[d] && (!active[d] || n >= k[d] + tt + 1)) begin
                    active[d]   = 1'b1;
                    k[d]        = n;
                    word[d]     = din_s[d] & mask;
                    echo_cur[d] = echo_next[d] & mask;
                end
            end
            m      = n - k[d];
            e_cs   = 1'b1;
            e_sck  = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_mosi = 1'b0;
            e_shdn = rst_s ? shdn_s[d] : 1'b1;
            if (active[d]) begin
                j = m / (2 * dv);
                if (j > w - 1) j = w - 1;
                e_mosi = word[d][w-1-j];
                if (m < tt) begin
                    e_cs   = 1'b0;
                    e_busy = 1'b1;
                    q      = m - dv;
                    e_sck  = (q >= 0) && ((q / dv) % 2 == 0) && (q / (2 * dv) < w);
                end else begin
                    e_done = (m == tt);
                end
            end
            act_dout = (d == 0) ? {24'b0, dout_a} : {20'b0, dout_b};
            chk($sformatf("dut%0d amp_cs", d), {31'b0, cs[d]}, {31'b0, e_cs});
            chk($sformatf("dut%0d spi_sck", d), {31'b0, sck[d]}, {31'b0, e_sck});
            chk($sformatf("dut%0d busy", d), {31'b0, busy[d]}, {31'b0, e_busy});
            chk($sformatf("dut%0d done", d), {31'b0, done[d]}, {31'b0, e_done});
            chk($sformatf("dut%0d spi_mosi", d), {31'b0, mosi[d]}, {31'b0, e_mosi});
            chk($sformatf("dut%0d amp_shdn", d), {31'b0, shdn[d]}, {31'b0, e_shdn});
            chk($sformatf("dut%0d data_out", d), act_dout, exp_dout[d]);
            chk($sformatf("dut%0d readback_err", d), {31'b0, rb_err[d]}, {31'b0, err[d]});
            if (sck[d] && !sck_prev[d]) begin
                cap[d] = {cap[d][30:0], mosi[d]};
                rises[d]++;
            end
            sck_prev[d] = sck[d];
            // Amplifier model: present the echo word MSB first ahead of each SCK rise.
            amp_dout[d] = 1'b0;
            if (active[d] && m < tt) begin
                j = (m < dv) ? 0 : (m - dv) / (2 * dv) + 1;
                if (j < w) amp_dout[d] = echo_cur[d][w-1-j];
            end
        end
    end

    task automatic start(input int d, input logic [31:0] w, input logic [31:0] e,
                         output int kacc);
        @(negedge clk);
        data_in[d]   = w;
        echo_next[d] = e;
        cap[d]       = '0;
        rises[d]     = 0;
        trig[d]      = 1'b1;
        @(negedge clk);
        kacc    = n;
        trig[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done[d]) begin
                at = n;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL dut%0d done timeout: got no done within %0d cycles, required one", d, limit);
    endtask

    initial begin : stim
        int ka, at, at2, cnt;
        RST       = 1'b1;
        trig      = '0;
        err_clr   = '0;
        shdn_req  = 2'b11;
        amp_dout  = '0;
        sck_prev  = '0;
        data_in   = '{32'h0, 32'h0};
        echo_next = '{32'h0, 32'h0};
        #1 RST = 1'b0;
        #1;
        chk("reset amp_cs", {30'b0, cs}, 32'h3);
        chk("reset busy", {30'b0, busy}, 32'h0);
        chk("reset amp_shdn", {30'b0, shdn}, 32'h3);
        repeat (3) @(negedge clk);
        RST = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle amp_cs", {30'b0, cs}, 32'h3);
        chk("idle spi_sck", {30'b0, sck}, 32'h0);
        chk("idle amp_shdn", {30'b0, shdn}, 32'h3);
        shdn_req = 2'b00;
        repeat (3) @(negedge clk);
        chk("shdn follows", {30'b0, shdn}, 32'h0);

        start(0, 32'hA5, 32'h00, ka);
        wait_done(0, 300, at);
        chk("A latency", at - ka, 85);
        chk("A mosi bits", cap[0] & 32'hFF, 32'hA5);
        chk("A sck rises", rises[0], 8);
        chk("A data_out 1", {24'b0, dout_a}, 32'h00);
        chk("A err 1", {31'b0, rb_err[0]}, 32'h0);

        start(0, 32'h3C, 32'hA5, ka);
        wait_done(0, 300, at);
        chk("A data_out 2", {24'b0, dout_a}, 32'hA5);
        chk("A err 2", {31'b0, rb_err[0]}, 32'h0);

        start(0, 32'h5A, 32'hFF, ka);
        wait_done(0, 300, at);
        chk("A data_out 3", {24'b0, dout_a}, 32'hFF);
        chk("A err 3", {31'b0, rb_err[0]}, 32'h1);
        @(negedge clk) err_clr[0] = 1'b1;
        @(negedge clk) err_clr[0] = 1'b0;
        chk("A err cleared", {31'b0, rb_err[0]}, 32'h0);

        start(0, 32'h77, 32'h5A, ka);
        repeat (39) @(negedge clk);
        trig[0] = 1'b1;
        @(negedge clk) trig[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done[0]) cnt++;
        end
        chk("A ignored trig done count", cnt, 1);
        chk("A ignored trig err", {31'b0, rb_err[0]}, 32'h0);

        @(negedge clk);
        data_in[0]   = 32'h66;
        echo_next[0] = 32'h66;
        trig[0]      = 1'b1;
        wait_done(0, 300, at);
        wait_done(0, 300, at2);
        trig[0] = 1'b0;
        chk("A back-to-back period", at2 - at, 86);

        start(0, 32'h99, 32'h00, ka);
        repeat (29) @(negedge clk);
        RST = 1'b0;
        #1;
        chk("mid reset amp_cs", {31'b0, cs[0]}, 32'h1);
        chk("mid reset busy", {31'b0, busy[0]}, 32'h0);
        repeat (3) @(negedge clk);
        RST = 1'b1;
        start(0, 32'h11, 32'h22, ka);
        wait_done(0, 300, at);
        chk("A post-reset data_out", {24'b0, dout_a}, 32'h22);
        chk("A post-reset err", {31'b0, rb_err[0]}, 32'h0);

        start(1, 32'hABC, 32'h5A3, ka);
        wait_done(1, 60, at);
        chk("B latency", at - ka, 25);
        chk("B mosi bits", cap[1] & 32'hFFF, 32'hABC);
        chk("B sck rises", rises[1], 12);
        chk("B data_out", {20'b0, dout_b}, 32'h5A3);
        chk("B err", {31'b0, rb_err[1]}, 32'h0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
